dice_game_ctrl: RTL
===================

# dice_game_ctrl

Game sequencer for the dice game: drives the roll enable of two 3-bit LFSR die generators, captures both faces after the roll button is released, and scores the throw under craps rules (natural, craps, point). It sits between the debounced roll/new-game buttons and the two die generators, and feeds the score, point and win/lose display logic.

## Interface

- SETTLE_CYCLES, 4, clk cycles waited after roll release before the die faces are sampled; legal range 1..15.
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous active-low reset.
- roll_btn  in  1  debounced, synchronous roll button level; 1 = held.
- new_game  in  1  synchronous one-cycle pulse; abandons the current game and starts a new one.
- die1  in  3  face value from die generator 1.
- die2  in  3  face value from die generator 2.
- roll_en  out  1  roll enable to both die generators.
- die1_q  out  3  last sampled face of die 1.
- die2_q  out  3  last sampled face of die 2.
- sum  out  4  die1_q + die2_q, range 2..12.
- point  out  4  established point; 0 = no point (come-out roll pending).
- roll_count  out  4  valid rolls scored this game, saturating at 15.
- busy  out  1  high in ROLL, WAIT and EVAL.
- win  out  1  level, high in WIN.
- lose  out  1  level, high in LOSE.
- die_err  out  1  one-cycle pulse when a sampled face is 0 or 7.

## Operation

- States: FIRST, ROLL, WAIT, EVAL, POINT, WIN, LOSE. Reset state is FIRST.
- Edge detect: roll_btn is registered every cycle into btn_q. A rise is roll_btn=1 and btn_q=0.
- FIRST/POINT: a rise moves to ROLL. Rises in every other state are ignored. A button still held when FIRST or POINT is re-entered does not trigger a roll; it must be released and pressed again.
- ROLL: roll_en=1, decoded from state. Stay while roll_btn=1. On roll_btn=0, go to WAIT and load settle_cnt=SETTLE_CYCLES-1.
- WAIT: roll_en=0. Decrement settle_cnt each cycle.
  - At settle_cnt=0: register die1 into die1_q and die2 into die2_q, register sum=die1+die2 (4-bit, no overflow), and go to EVAL.
- EVAL (exactly one cycle):
  - If die1_q or die2_q is 0 or 7: pulse die_err. roll_count, point and state outcome are unchanged. Return to FIRST if point=0, else POINT.
  - Come-out roll (point=0):
    - sum 7 or 11 -> WIN.
    - sum 2, 3 or 12 -> LOSE.
    - Otherwise point<=sum and go to POINT.
  - Point roll (point≠0):
    - sum=point -> WIN.
    - sum=7 -> LOSE.
    - Otherwise stay in POINT.
  - Every valid EVAL does roll_count<=min(roll_count+1,15).
- WIN/LOSE: hold. Outputs are frozen and only new_game leaves the state.
- new_game:
  - Accepted in any state, including ROLL and WAIT.
  - Next state is FIRST.
  - Clears point, sum, die1_q, die2_q and roll_count.
  - roll_en drops the next cycle.
  - new_game has priority over a same-cycle rise, which is discarded; btn_q still updates.
- Reset (asynchronous, any time):
  - All outputs and registers go to 0, state goes to FIRST, btn_q goes to 0.
  - If roll_btn is held through reset release, it produces a rise on the first clock after release.

## Timing

- Rise sampled at edge N: ROLL from edge N, roll_en high after edge N.
- Release sampled at edge M: WAIT from edge M, roll_en low after edge M.
- Dice sampled at edge M+SETTLE_CYCLES. EVAL occupies the next cycle. win, lose, point and roll_count are updated at edge M+SETTLE_CYCLES+1.
- Release-to-outcome latency is SETTLE_CYCLES+1 cycles.
- die_err is high for the single cycle following EVAL.
- Minimum roll: press held for 1 cycle gives roll_en high for exactly 1 cycle.

## Test plan

- Come-out natural: reset, press 3 cycles, release, force die1=3, die2=4. Require sum=7, win=1 at release+5 cycles (SETTLE=4), roll_count=1, point=0.
- Craps: come-out with die1=1, die2=1. Require sum=2, lose=1, win=0. A further press is ignored: roll_en stays 0.
- Point made: come-out 2+4 gives point=6 and state POINT. Second roll 1+4 keeps point=6 with roll_count=2. Third roll 5+1 gives win=1 and roll_count=3.
- Seven-out: point=8 (4+4), then 3+4. Require lose=1, point=8 retained, roll_count=2.
- Invalid face: come-out with die1=0, die2=5. Require a one-cycle die_err, point=0, roll_count=0, back in FIRST. A subsequent valid roll scores normally.
- Abort/reset: new_game while roll_btn is held in ROLL. Require roll_en=0 next cycle, state FIRST, all counters 0, no roll until release then re-press. rst asserted during WAIT: all outputs 0 immediately, without waiting for clk.

Source files
------------

// File: rtl/dice_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dice_game_ctrl
// Purpose  : Craps game sequencer. Enables two die generators while the roll
//            button is held, waits a settle time after release, samples both
//            faces and scores the throw (natural / craps / point).
// Ports    : clk, rst (async, active-low)
//            roll_btn   - debounced roll button level
//            new_game   - one-cycle pulse, abandons the game
//            die1/die2  - die generator faces
//            roll_en    - roll enable to both die generators
//            die1_q/die2_q/sum - last sampled faces and their sum
//            point      - established point, 0 = come-out pending
//            roll_count - valid rolls this game, saturating at 15
//            busy/win/lose - state decodes
//            die_err    - one-cycle pulse on an illegal face (0 or 7)
// Revision : 1.0 - initial release
// ============================================================================
module dice_game_ctrl #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       roll_btn,
  input  logic       new_game,
  input  logic [2:0] die1,
  input  logic [2:0] die2,
  output logic       roll_en,
  output logic [2:0] die1_q,
  output logic [2:0] die2_q,
  output logic [3:0] sum,
  output logic [3:0] point,
  output logic [3:0] roll_count,
  output logic       busy,
  output logic       win,
  output logic       lose,
  output logic       die_err
);

  typedef enum logic [2:0] {
    S_FIRST = 3'd0,
    S_ROLL  = 3'd1,
    S_WAIT  = 3'd2,
    S_EVAL  = 3'd3,
    S_POINT = 3'd4,
    S_WIN   = 3'd5,
    S_LOSE  = 3'd6
  } state_t;

  localparam logic [3:0] c_SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     r_state, w_state_nxt;
  logic       r_btn_q;
  logic [3:0] r_settle_cnt, w_settle_nxt;
  logic [2:0] r_die1_q, w_die1_nxt;
  logic [2:0] r_die2_q, w_die2_nxt;
  logic [3:0] r_sum, w_sum_nxt;
  logic [3:0] r_point, w_point_nxt;
  logic [3:0] r_roll_count, w_count_nxt;
  logic       r_die_err, w_die_err_nxt;

  logic       w_rise;
  logic       w_face_bad;
  logic [3:0] w_count_inc;

  // Only a fresh press counts; a button still held from an earlier phase
  // keeps r_btn_q high and so cannot start a roll.
  assign w_rise      = roll_btn & ~r_btn_q;
  assign w_face_bad  = (r_die1_q == 3'd0) || (r_die1_q == 3'd7) ||
                       (r_die2_q == 3'd0) || (r_die2_q == 3'd7);
  assign w_count_inc = (r_roll_count == 4'd15) ? 4'd15 : r_roll_count + 4'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_FIRST;
      r_btn_q      <= 1'b0;
      r_settle_cnt <= 4'd0;
      r_die1_q     <= 3'd0;
      r_die2_q     <= 3'd0;
      r_sum        <= 4'd0;
      r_point      <= 4'd0;
      r_roll_count <= 4'd0;
      r_die_err    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_btn_q      <= roll_btn;
      r_settle_cnt <= w_settle_nxt;
      r_die1_q     <= w_die1_nxt;
      r_die2_q     <= w_die2_nxt;
      r_sum        <= w_sum_nxt;
      r_point      <= w_point_nxt;
      r_roll_count <= w_count_nxt;
      r_die_err    <= w_die_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_settle_nxt  = r_settle_cnt;
    w_die1_nxt    = r_die1_q;
    w_die2_nxt    = r_die2_q;
    w_sum_nxt     = r_sum;
    w_point_nxt   = r_point;
    w_count_nxt   = r_roll_count;
    w_die_err_nxt = 1'b0;

    if (new_game) begin
      // Wins over any same-cycle rise; that press is simply dropped.
      w_state_nxt = S_FIRST;
      w_die1_nxt  = 3'd0;
      w_die2_nxt  = 3'd0;
      w_sum_nxt   = 4'd0;
      w_point_nxt = 4'd0;
      w_count_nxt = 4'd0;
    end else begin
      case (r_state)
        S_FIRST, S_POINT: begin
          if (w_rise) w_state_nxt = S_ROLL;
        end
        S_ROLL: begin
          if (!roll_btn) begin
            w_state_nxt  = S_WAIT;
            w_settle_nxt = c_SETTLE_LOAD;
          end
        end
        S_WAIT: begin
          if (r_settle_cnt == 4'd0) begin
            w_die1_nxt  = die1;
            w_die2_nxt  = die2;
            w_sum_nxt   = {1'b0, die1} + {1'b0, die2};
            w_state_nxt = S_EVAL;
          end else begin
            w_settle_nxt = r_settle_cnt - 4'd1;
          end
        end
        S_EVAL: begin
          if (w_face_bad) begin
            // Illegal throw: flag it and return without scoring.
            w_die_err_nxt = 1'b1;
            w_state_nxt   = (r_point == 4'd0) ? S_FIRST : S_POINT;
          end else begin
            w_count_nxt = w_count_inc;
            if (r_point == 4'd0) begin
              if (r_sum == 4'd7 || r_sum == 4'd11) begin
                w_state_nxt = S_WIN;
              end else if (r_sum == 4'd2 || r_sum == 4'd3 || r_sum == 4'd12) begin
                w_state_nxt = S_LOSE;
              end else begin
                w_point_nxt = r_sum;
                w_state_nxt = S_POINT;
              end
            end else begin
              if (r_sum == r_point)   w_state_nxt = S_WIN;
              else if (r_sum == 4'd7) w_state_nxt = S_LOSE;
              else                    w_state_nxt = S_POINT;
            end
          end
        end
        S_WIN, S_LOSE: begin
          w_state_nxt = r_state;
        end
        default: begin
          w_state_nxt = S_FIRST;
        end
      endcase
    end
  end

  assign roll_en    = (r_state == S_ROLL);
  assign busy       = (r_state == S_ROLL) || (r_state == S_WAIT) || (r_state == S_EVAL);
  assign win        = (r_state == S_WIN);
  assign lose       = (r_state == S_LOSE);
  assign die1_q     = r_die1_q;
  assign die2_q     = r_die2_q;
  assign sum        = r_sum;
  assign point      = r_point;
  assign roll_count = r_roll_count;
  assign die_err    = r_die_err;

endmodule
`default_nettype wire
